// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM: sequences IF/ID/EX/MEM/WB for the datapath muxes and enables.
// Optional feature: define ECALL_HALT_EN to let ECALL with halt_cond=1 enter the absorbing HALT state.
module mc_control_fsm (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       bcond,
  input  logic       halt_cond,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_source,
  output logic       is_halted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_PC4  = 3'd5,
    S_HALT = 3'd6,
    S_BAD  = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  state_t cur, nxt;

`ifndef ECALL_HALT_EN
  logic unused_halt_cond;
  assign unused_halt_cond = halt_cond;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cur <= S_IF;
    else          cur <= nxt;
  end

  assign state = cur;

  always_comb begin
    nxt           = S_IF;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 1'b0;
    is_halted     = 1'b0;

    case (cur)
      S_IF: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          nxt      = S_ID;
        end else begin
          nxt = S_IF;
        end
      end
      S_ID: begin
        alu_src_b = 2'b10;
        case (opcode)
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: nxt = S_EX;
`ifdef ECALL_HALT_EN
          OP_ECALL: nxt = halt_cond ? S_HALT : S_PC4;
`endif
          default: nxt = S_PC4;
        endcase
      end
      S_EX: begin
        case (opcode)
          OP_R, OP_I: begin
            alu_src_a = 1'b1;
            alu_src_b = (opcode == OP_R) ? 2'b00 : 2'b10;
            alu_op    = 2'b10;
            nxt       = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nxt       = S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 1'b1;
            nxt           = bcond ? S_IF : S_PC4;
          end
          OP_JAL: begin
            alu_src_b = 2'b01;
            reg_write = 1'b1;
            wb_sel    = 2'b10;
            pc_write  = 1'b1;
            pc_source = 1'b1;
            nxt       = S_IF;
          end
          OP_JALR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nxt       = S_WB;
          end
          default: nxt = S_IF;
        endcase
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = (opcode == OP_LOAD);
        mem_write = (opcode == OP_STORE);
        if (!mem_ready) begin
          nxt = S_MEM;
        end else if (opcode == OP_LOAD) begin
          nxt = S_WB;
        end else begin
          // Store retires here, so PC+4 is written back without a separate PC4 cycle
          pc_write  = (opcode == OP_STORE);
          alu_src_b = 2'b01;
          nxt       = S_IF;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_source = (opcode == OP_JALR);
        case (opcode)
          OP_LOAD: wb_sel = 2'b01;
          OP_JALR: wb_sel = 2'b10;
          default: wb_sel = 2'b00;
        endcase
        nxt = S_IF;
      end
      S_PC4: begin
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
        nxt       = S_IF;
      end
      S_HALT: begin
        is_halted = 1'b1;
        nxt       = S_HALT;
      end
      default: nxt = S_IF;
    endcase

    // Reset must silence every enable at once, even though state decodes to IF
    if (!reset_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      wb_sel        = 2'b00;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 1'b0;
      is_halted     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed instructions then random instruction stream,
// each instruction expanded into an expected per-cycle script. Honours ECALL_HALT_EN.
module tb_mc_control_fsm;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       bcond = 1'b0;
  logic       halt_cond = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic [1:0] wb_sel, alu_src_b, alu_op;
  logic       alu_src_a, pc_source, is_halted;
  logic [2:0] state;

  mc_control_fsm dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .bcond(bcond), .halt_cond(halt_cond), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .is_halted(is_halted), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       pc_source, is_halted;
  } outs_t;

  typedef struct {
    bit    mr, bc, hc;
    outs_t e;
  } step_t;

  step_t sq[$];
  int n_assert = 0;
  int n_fail = 0;

  function automatic outs_t z(logic [2:0] st);
    outs_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic outs_t observed();
    outs_t o;
    o.st = state;  o.pc_write = pc_write;  o.pc_write_cond = pc_write_cond;
    o.i_or_d = i_or_d;  o.mem_read = mem_read;  o.mem_write = mem_write;
    o.ir_write = ir_write;  o.reg_write = reg_write;  o.wb_sel = wb_sel;
    o.alu_src_a = alu_src_a;  o.alu_src_b = alu_src_b;  o.alu_op = alu_op;
    o.pc_source = pc_source;  o.is_halted = is_halted;
    return o;
  endfunction

  task automatic checkOutput(string tag, outs_t exp);
    outs_t obs;
    obs = observed();
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(bit mr, bit bc, bit hc);
    mem_ready = mr;
    bcond     = bc;
    halt_cond = hc;
  endtask

  task automatic push(bit mr, bit bc, bit hc, outs_t e);
    step_t s;
    s.mr = mr; s.bc = bc; s.hc = hc; s.e = e;
    sq.push_back(s);
  endtask

  task automatic push_pc4();
    outs_t e;
    e = z(5); e.alu_src_b = 2'b01; e.pc_write = 1'b1;
    push(rb(), rb(), rb(), e);
  endtask

  // Expected cycle script for one instruction, derived from the instruction-class rules
  task automatic build(logic [6:0] opc, int if_wait, int mem_wait, bit bc, bit hc, output bit halted);
    outs_t e;
    halted = 1'b0;
    e = z(0); e.mem_read = 1'b1;
    repeat (if_wait) push(1'b0, rb(), rb(), e);
    e.ir_write = 1'b1;
    push(1'b1, rb(), rb(), e);
    e = z(1); e.alu_src_b = 2'b10;
    push(rb(), rb(), (opc == OP_ECALL) ? hc : rb(), e);
    case (opc)
      OP_R, OP_I: begin
        e = z(2); e.alu_src_a = 1'b1; e.alu_op = 2'b10;
        e.alu_src_b = (opc == OP_R) ? 2'b00 : 2'b10;
        push(rb(), rb(), rb(), e);
        e = z(4); e.reg_write = 1'b1; e.wb_sel = 2'b00; e.pc_write = 1'b1; e.alu_src_b = 2'b01;
        push(rb(), rb(), rb(), e);
      end
      OP_LOAD, OP_STORE: begin
        e = z(2); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        push(rb(), rb(), rb(), e);
        e = z(3); e.i_or_d = 1'b1;
        if (opc == OP_LOAD) e.mem_read = 1'b1; else e.mem_write = 1'b1;
        repeat (mem_wait) push(1'b0, rb(), rb(), e);
        if (opc == OP_STORE) begin e.pc_write = 1'b1; e.alu_src_b = 2'b01; end
        push(1'b1, rb(), rb(), e);
        if (opc == OP_LOAD) begin
          e = z(4); e.reg_write = 1'b1; e.wb_sel = 2'b01; e.pc_write = 1'b1; e.alu_src_b = 2'b01;
          push(rb(), rb(), rb(), e);
        end
      end
      OP_BRANCH: begin
        e = z(2); e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_write_cond = 1'b1; e.pc_source = 1'b1;
        push(rb(), bc, rb(), e);
        if (!bc) push_pc4();
      end
      OP_JAL: begin
        e = z(2); e.alu_src_b = 2'b01; e.reg_write = 1'b1; e.wb_sel = 2'b10;
        e.pc_write = 1'b1; e.pc_source = 1'b1;
        push(rb(), rb(), rb(), e);
      end
      OP_JALR: begin
        e = z(2); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        push(rb(), rb(), rb(), e);
        e = z(4); e.reg_write = 1'b1; e.wb_sel = 2'b10; e.pc_write = 1'b1;
        e.alu_src_b = 2'b01; e.pc_source = 1'b1;
        push(rb(), rb(), rb(), e);
      end
      OP_ECALL: begin
`ifdef ECALL_HALT_EN
        if (hc) begin
          e = z(6); e.is_halted = 1'b1;
          repeat (10) push(rb(), rb(), rb(), e);
          halted = 1'b1;
        end else begin
          push_pc4();
        end
`else
        push_pc4();
`endif
      end
      default: push_pc4();
    endcase
  endtask

  // Plays queued steps starting and ending on a falling edge
  task automatic play(string tag, int limit);
    step_t s;
    int k;
    k = 0;
    while (sq.size() > 0 && k < limit) begin
      s = sq.pop_front();
      applyStimulus(s.mr, s.bc, s.hc);
      #1 checkOutput($sformatf("%s_c%0d", tag, k), s.e);
      @(negedge clk);
      k++;
    end
    sq.delete();
  endtask

  task automatic doReset(string tag);
    reset_n = 1'b0;
    #1 checkOutput(tag, z(0));
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic runInstr(string tag, logic [6:0] opc, int iw, int mw, bit bc, bit hc);
    bit halted;
    opcode = opc;
    build(opc, iw, mw, bc, hc, halted);
    play(tag, 1000);
    if (halted) doReset({tag, "_rst"});
  endtask

  initial begin
    logic [6:0] pool [10];
    outs_t e;
    pool = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_ECALL, 7'h7f, 7'h00};

    // Outputs stay silent while reset is held, even with mem_ready high in IF
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1);
    #1 checkOutput("reset_hold", z(0));
    @(negedge clk);
    #1 checkOutput("reset_hold2", z(0));
    @(negedge clk);
    reset_n = 1'b1;

    runInstr("r_add", OP_R, 0, 0, 1'b0, 1'b0);
    runInstr("load_wait3", OP_LOAD, 1, 3, 1'b0, 1'b0);
    runInstr("branch_taken", OP_BRANCH, 0, 0, 1'b1, 1'b0);
    runInstr("branch_not", OP_BRANCH, 0, 0, 1'b0, 1'b0);
    runInstr("jal", OP_JAL, 0, 0, 1'b0, 1'b0);
    runInstr("jalr", OP_JALR, 2, 0, 1'b0, 1'b0);
    runInstr("store", OP_STORE, 0, 2, 1'b0, 1'b0);
    runInstr("i_arith", OP_I, 0, 0, 1'b0, 1'b0);
    runInstr("unknown", 7'h7f, 0, 0, 1'b0, 1'b0);
    runInstr("ecall_hc1", OP_ECALL, 0, 0, 1'b0, 1'b1);
    runInstr("ecall_hc0", OP_ECALL, 0, 0, 1'b0, 1'b0);

    // Reset dropped during a STORE memory wait must abort without any write
    begin
      bit dummy;
      opcode = OP_STORE;
      build(OP_STORE, 0, 5, 1'b0, 1'b0, dummy);
      play("store_rst", 4);
      applyStimulus(1'b0, 1'b0, 1'b0);
      e = z(3); e.i_or_d = 1'b1; e.mem_write = 1'b1;
      #1 checkOutput("store_mem_wait", e);
      #1 reset_n = 1'b0;
      #1 checkOutput("store_rst_now", z(0));
      @(negedge clk);
      #1 checkOutput("store_rst_held", z(0));
      reset_n = 1'b1;
      e = z(0); e.mem_read = 1'b1;
      #1 checkOutput("store_rst_release", e);
      @(negedge clk);
    end

    for (int i = 0; i < 150; i++) begin
      logic [6:0] opc;
      opc = (i % 10 == 9) ? 7'($urandom) : pool[$urandom_range(0, 8)];
      runInstr($sformatf("rnd%0d", i), opc, $urandom_range(0, 2), $urandom_range(0, 3), rb(), rb());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
